// File: rtl/mcpu_core_regfile_sb_if.sv
// Decode/write-back bundle between the MCPU pipeline and the register file scoreboard.
// The master drives register numbers, issue and write-back; the slave is the register file.
interface mcpu_core_regfile_sb_if #(
  parameter int NLANES = 4,
  parameter int DATA_W = 32,
  parameter int AW     = 5
);
  logic [NLANES*AW-1:0]     d2rf_rs_num;
  logic [NLANES*AW-1:0]     d2rf_rt_num;
  logic [NLANES*DATA_W-1:0] rf2d_rs_data;
  logic [NLANES*DATA_W-1:0] rf2d_rt_data;
  logic [NLANES-1:0]        d2rf_issue_valid;
  logic [NLANES*AW-1:0]     d2rf_rd_num;
  logic                     d2rf_issue_go;
  logic                     rf2d_hazard;
  logic [NLANES*AW-1:0]     wb2rf_rd_num;
  logic [NLANES*DATA_W-1:0] wb2rf_rd_data;
  logic [NLANES-1:0]        wb2rf_rd_we;
  logic [NLANES-1:0]        wb2rf_pred_we;
  logic [NLANES-1:0]        wb2rf_retire;

  modport master (
    output d2rf_rs_num, d2rf_rt_num, d2rf_issue_valid, d2rf_rd_num, d2rf_issue_go,
           wb2rf_rd_num, wb2rf_rd_data, wb2rf_rd_we, wb2rf_pred_we, wb2rf_retire,
    input  rf2d_rs_data, rf2d_rt_data, rf2d_hazard
  );

  modport slave (
    input  d2rf_rs_num, d2rf_rt_num, d2rf_issue_valid, d2rf_rd_num, d2rf_issue_go,
           wb2rf_rd_num, wb2rf_rd_data, wb2rf_rd_we, wb2rf_pred_we, wb2rf_retire,
    output rf2d_rs_data, rf2d_rt_data, rf2d_hazard
  );
endinterface

// File: rtl/mcpu_core_regfile_sb.sv
// Multi-lane MCPU register file with predicate bits, write bypass and a per-register
// pending-count scoreboard that produces the bundle-level decode hazard.
module mcpu_core_regfile_sb #(
  parameter int NLANES   = 4,
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int NPREDS   = 3,
  parameter int BYPASS   = 1,
  parameter int SB_CNT_W = 3
) (
  input  logic                 clkrst_core_clk,
  input  logic                 clkrst_core_rst,
  mcpu_core_regfile_sb_if.slave rf_if,
  input  logic [DATA_W-1:0]    rf_hw_in,
  output logic [DATA_W-1:0]    rf_r0,
  output logic [NPREDS-1:0]    preds,
  output logic [NREGS-1:0]     rf_pending,
  output logic                 rf_sb_err
);
  localparam int AW  = $clog2(NREGS);
  localparam int PW  = (NPREDS > 1) ? $clog2(NPREDS) : 1;
  localparam int EW  = SB_CNT_W + 1;
  localparam logic [AW-1:0] TOP_REG  = AW'(NREGS - 1);
  localparam logic [PW:0]   NPRED_LIM = (PW + 1)'(NPREDS);

  logic [DATA_W-1:0]   mem_reg [NREGS];
  logic [SB_CNT_W-1:0] cnt_reg [NREGS];
  logic [SB_CNT_W-1:0] cnt_next [NREGS];
  logic [NPREDS-1:0]   preds_reg;
  logic                sb_err_reg;
  logic [NREGS-1:0]    uflow;
  logic [NREGS-1:0]    busy;

  logic [AW-1:0]       rs_num  [NLANES];
  logic [AW-1:0]       rt_num  [NLANES];
  logic [AW-1:0]       rd_num  [NLANES];
  logic [AW-1:0]       wb_num  [NLANES];
  logic [PW-1:0]       wb_pidx [NLANES];
  logic [DATA_W-1:0]   wb_data [NLANES];

  for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
    assign rs_num[gi]  = rf_if.d2rf_rs_num[gi*AW +: AW];
    assign rt_num[gi]  = rf_if.d2rf_rt_num[gi*AW +: AW];
    assign rd_num[gi]  = rf_if.d2rf_rd_num[gi*AW +: AW];
    assign wb_num[gi]  = rf_if.wb2rf_rd_num[gi*AW +: AW];
    assign wb_pidx[gi] = rf_if.wb2rf_rd_num[gi*AW +: PW];
    assign wb_data[gi] = rf_if.wb2rf_rd_data[gi*DATA_W +: DATA_W];
  end

  // Lanes are visited high to low so the lowest-numbered lane's write lands last.
  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      for (int r = 0; r < NREGS; r++) mem_reg[r] <= '0;
      preds_reg <= '0;
    end else begin
      for (int i = NLANES - 1; i >= 0; i--) begin
        if (rf_if.wb2rf_rd_we[i] && wb_num[i] != TOP_REG)
          mem_reg[wb_num[i]] <= wb_data[i];
        if (rf_if.wb2rf_pred_we[i] && {1'b0, wb_pidx[i]} < NPRED_LIM)
          preds_reg[wb_pidx[i]] <= wb_data[i][0];
      end
    end
  end

  always_comb begin
    rf_if.rf2d_rs_data = '0;
    rf_if.rf2d_rt_data = '0;
    for (int l = 0; l < NLANES; l++) begin
      rf_if.rf2d_rs_data[l*DATA_W +: DATA_W] = mem_reg[rs_num[l]];
      rf_if.rf2d_rt_data[l*DATA_W +: DATA_W] = mem_reg[rt_num[l]];
      if (BYPASS != 0) begin
        for (int i = NLANES - 1; i >= 0; i--) begin
          if (rf_if.wb2rf_rd_we[i] && wb_num[i] == rs_num[l])
            rf_if.rf2d_rs_data[l*DATA_W +: DATA_W] = wb_data[i];
          if (rf_if.wb2rf_rd_we[i] && wb_num[i] == rt_num[l])
            rf_if.rf2d_rt_data[l*DATA_W +: DATA_W] = wb_data[i];
        end
      end
      if (rs_num[l] == TOP_REG) rf_if.rf2d_rs_data[l*DATA_W +: DATA_W] = rf_hw_in;
      if (rt_num[l] == TOP_REG) rf_if.rf2d_rt_data[l*DATA_W +: DATA_W] = rf_hw_in;
    end
  end

  // Per-register net count; a retire with nothing outstanding clamps and flags underflow.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_sb
    localparam logic [AW-1:0] REG_ID = AW'(gi);
    logic [EW-1:0] inc;
    logic [EW-1:0] dec;
    logic [EW-1:0] sum;

    always_comb begin
      inc = '0;
      dec = '0;
      for (int i = 0; i < NLANES; i++) begin
        if (rf_if.d2rf_issue_go && rf_if.d2rf_issue_valid[i] && rd_num[i] == REG_ID)
          inc = inc + EW'(1);
        if (rf_if.wb2rf_retire[i] && wb_num[i] == REG_ID)
          dec = dec + EW'(1);
      end
      sum = {1'b0, cnt_reg[gi]} + inc;
    end

    assign uflow[gi]      = dec > sum;
    assign cnt_next[gi]   = uflow[gi] ? '0 : SB_CNT_W'(sum - dec);
    assign rf_pending[gi] = |cnt_reg[gi];
  end

  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      for (int r = 0; r < NREGS; r++) cnt_reg[r] <= '0;
      sb_err_reg <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) cnt_reg[r] <= cnt_next[r];
      if (|uflow) sb_err_reg <= 1'b1;
    end
  end

  // The top register is fed from rf_hw_in and is never a hazard source.
  always_comb begin
    busy = rf_pending;
    busy[NREGS-1] = 1'b0;
    rf_if.rf2d_hazard = 1'b0;
    for (int i = 0; i < NLANES; i++) begin
      if (rf_if.d2rf_issue_valid[i] &&
          (busy[rs_num[i]] || busy[rt_num[i]] || busy[rd_num[i]]))
        rf_if.rf2d_hazard = 1'b1;
    end
  end

  assign rf_r0     = mem_reg[0];
  assign preds     = preds_reg;
  assign rf_sb_err = sb_err_reg;
endmodule

// File: tb/tb_mcpu_core_regfile_sb.sv
// Directed vector bench for mcpu_core_regfile_sb: a cycle table plus hand sequences for
// the reset-time read sweep and the asynchronous mid-stream reset.
module tb_mcpu_core_regfile_sb;
  localparam int NL = 4;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam logic [31:0] HW_VAL = 32'hCAFE0000;

  logic          clk;
  logic          rst;
  logic [DW-1:0] rf_hw_in;
  logic [DW-1:0] rf_r0;
  logic [2:0]    preds;
  logic [31:0]   rf_pending;
  logic          rf_sb_err;

  mcpu_core_regfile_sb_if #(.NLANES(NL), .DATA_W(DW), .AW(AW)) bus ();

  mcpu_core_regfile_sb #(
    .NLANES(NL), .DATA_W(DW), .NREGS(32), .NPREDS(3), .BYPASS(1), .SB_CNT_W(3)
  ) dut (
    .clkrst_core_clk (clk),
    .clkrst_core_rst (rst),
    .rf_if           (bus),
    .rf_hw_in        (rf_hw_in),
    .rf_r0           (rf_r0),
    .preds           (preds),
    .rf_pending      (rf_pending),
    .rf_sb_err       (rf_sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [19:0]  rs, rt, rd, wbn;
    logic [3:0]   valid, we, pwe, ret;
    logic         go;
    logic [127:0] wbd;
    logic [31:0]  e_rs0;
    logic         e_haz;
    logic [31:0]  e_pend;
    logic [2:0]   e_preds;
    logic [31:0]  e_r0;
    logic         e_err;
  } vec_t;

  vec_t tbl[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic logic [19:0] ln(int lane, int num);
    return 20'(num) << (lane * AW);
  endfunction

  function automatic logic [127:0] ld(int lane, logic [31:0] d);
    return 128'(d) << (lane * DW);
  endfunction

  function automatic vec_t clr_in(vec_t v, string nm);
    vec_t o;
    o = v;
    o.name = nm;
    o.rs = '0; o.rt = '0; o.rd = '0; o.wbn = '0;
    o.valid = '0; o.we = '0; o.pwe = '0; o.ret = '0;
    o.go = 1'b0; o.wbd = '0;
    return o;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic drive(vec_t v);
    bus.d2rf_rs_num      = v.rs;
    bus.d2rf_rt_num      = v.rt;
    bus.d2rf_rd_num      = v.rd;
    bus.d2rf_issue_valid = v.valid;
    bus.d2rf_issue_go    = v.go;
    bus.wb2rf_rd_num     = v.wbn;
    bus.wb2rf_rd_data    = v.wbd;
    bus.wb2rf_rd_we      = v.we;
    bus.wb2rf_pred_we    = v.pwe;
    bus.wb2rf_retire     = v.ret;
  endtask

  initial begin
    vec_t t;
    logic [127:0] exp_all;

    t.name = "";
    t.e_rs0 = '0; t.e_haz = 1'b0; t.e_pend = '0; t.e_preds = '0; t.e_r0 = '0; t.e_err = 1'b0;

    t = clr_in(t, "idle_r31");
    t.rs = ln(0, 31); t.e_rs0 = HW_VAL;
    tbl.push_back(t);

    t = clr_in(t, "wb_collide_r5");
    t.rs = ln(0, 5);
    t.wbn = ln(3, 5) | ln(0, 5); t.we = 4'b1001;
    t.wbd = ld(3, 32'h33) | ld(0, 32'h11);
    t.e_rs0 = 32'h11;
    tbl.push_back(t);

    t = clr_in(t, "read_r5");
    t.rs = ln(0, 5); t.e_rs0 = 32'h11;
    tbl.push_back(t);

    t = clr_in(t, "wr_r0_r31");
    t.rs = ln(0, 0);
    t.wbn = ln(2, 0) | ln(1, 31); t.we = 4'b0110;
    t.wbd = ld(2, 32'hDEAD) | ld(1, 32'h1234);
    t.e_rs0 = 32'hDEAD; t.e_r0 = 32'hDEAD;
    tbl.push_back(t);

    t = clr_in(t, "pred_2_3");
    t.rs = ln(0, 31); t.e_rs0 = HW_VAL;
    t.wbn = ln(1, 2) | ln(2, 3); t.pwe = 4'b0110;
    t.wbd = ld(1, 32'h1) | ld(2, 32'h1);
    t.e_preds = 3'b100;
    tbl.push_back(t);

    t = clr_in(t, "pred_collide0");
    t.rs = ln(0, 0); t.e_rs0 = 32'hDEAD;
    t.wbn = ln(0, 0) | ln(3, 0); t.pwe = 4'b1001;
    t.wbd = ld(0, 32'h1) | ld(3, 32'h0);
    t.e_preds = 3'b101;
    tbl.push_back(t);

    t = clr_in(t, "issue_r7");
    t.rd = ln(0, 7); t.valid = 4'b0001; t.go = 1'b1;
    t.e_rs0 = 32'hDEAD; t.e_haz = 1'b0; t.e_pend = 32'h80;
    tbl.push_back(t);

    t = clr_in(t, "haz_r7_retire");
    t.rs = ln(1, 7); t.valid = 4'b0010;
    t.wbn = ln(2, 7); t.ret = 4'b0100;
    t.e_haz = 1'b1; t.e_pend = '0;
    tbl.push_back(t);

    t = clr_in(t, "r7_cleared");
    t.rs = ln(1, 7); t.valid = 4'b0010;
    t.e_haz = 1'b0;
    tbl.push_back(t);

    t = clr_in(t, "issue2_r9");
    t.rd = ln(0, 9) | ln(1, 9); t.valid = 4'b0011; t.go = 1'b1;
    t.e_haz = 1'b0; t.e_pend = 32'h200;
    tbl.push_back(t);

    t = clr_in(t, "retire1_r9");
    t.wbn = ln(0, 9); t.ret = 4'b0001;
    t.e_pend = 32'h200;
    tbl.push_back(t);

    t = clr_in(t, "iss_ret_r9");
    t.rd = ln(0, 9); t.valid = 4'b0001; t.go = 1'b1;
    t.wbn = ln(1, 9); t.ret = 4'b0010;
    t.e_haz = 1'b1; t.e_pend = 32'h200;
    tbl.push_back(t);

    t = clr_in(t, "retire2_r9");
    t.wbn = ln(3, 9); t.ret = 4'b1000;
    t.e_haz = 1'b0; t.e_pend = '0;
    tbl.push_back(t);

    t = clr_in(t, "issue_r31");
    t.rd = ln(0, 31); t.valid = 4'b0001; t.go = 1'b1;
    t.e_haz = 1'b0; t.e_pend = 32'h8000_0000;
    tbl.push_back(t);

    t = clr_in(t, "r31_nohaz");
    t.rs = ln(0, 31); t.rt = ln(0, 31); t.valid = 4'b0001; t.e_rs0 = HW_VAL;
    t.wbn = ln(0, 31); t.ret = 4'b0001;
    t.e_haz = 1'b0; t.e_pend = '0;
    tbl.push_back(t);

    t = clr_in(t, "uflow_r4");
    t.wbn = ln(0, 4); t.ret = 4'b0001;
    t.e_rs0 = 32'hDEAD; t.e_err = 1'b1;
    tbl.push_back(t);

    t = clr_in(t, "err_sticky");
    t.e_err = 1'b1;
    tbl.push_back(t);

    rf_hw_in = HW_VAL;
    rst = 1'b1;
    t = clr_in(t, "zero");
    drive(t);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_pending", 128'(rf_pending), 128'h0);
    chk("rst_preds", 128'(preds), 128'h0);
    chk("rst_r0", 128'(rf_r0), 128'h0);
    chk("rst_err", 128'(rf_sb_err), 128'h0);
    chk("rst_haz", 128'(bus.rf2d_hazard), 128'h0);

    for (int r = 0; r < 32; r++) begin
      bus.d2rf_rs_num = {4{5'(r)}};
      bus.d2rf_rt_num = {4{5'(r)}};
      #1;
      exp_all = (r == 31) ? {4{HW_VAL}} : '0;
      chk($sformatf("rst_rs_r%0d", r), bus.rf2d_rs_data, exp_all);
      chk($sformatf("rst_rt_r%0d", r), bus.rf2d_rt_data, exp_all);
    end

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk({tbl[i].name, "/rs0"}, 128'(bus.rf2d_rs_data[31:0]), 128'(tbl[i].e_rs0));
      chk({tbl[i].name, "/haz"}, 128'(bus.rf2d_hazard), 128'(tbl[i].e_haz));
      @(posedge clk);
      #1;
      chk({tbl[i].name, "/pend"}, 128'(rf_pending), 128'(tbl[i].e_pend));
      chk({tbl[i].name, "/preds"}, 128'(preds), 128'(tbl[i].e_preds));
      chk({tbl[i].name, "/r0"}, 128'(rf_r0), 128'(tbl[i].e_r0));
      chk({tbl[i].name, "/err"}, 128'(rf_sb_err), 128'(tbl[i].e_err));
    end

    // Asynchronous reset in the middle of the high phase, then an orphaned retire.
    @(negedge clk);
    t = clr_in(t, "issue_r10");
    t.rd = ln(0, 10); t.valid = 4'b0001; t.go = 1'b1;
    drive(t);
    @(posedge clk);
    #1;
    chk("mid_pend_r10", 128'(rf_pending), 128'h400);
    t = clr_in(t, "quiet");
    t.rs = ln(0, 5);
    drive(t);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_pending", 128'(rf_pending), 128'h0);
    chk("arst_err", 128'(rf_sb_err), 128'h0);
    chk("arst_r0", 128'(rf_r0), 128'h0);
    chk("arst_preds", 128'(preds), 128'h0);
    chk("arst_rd_r5", 128'(bus.rf2d_rs_data[31:0]), 128'h0);
    @(negedge clk);
    rst = 1'b0;
    t = clr_in(t, "late_retire");
    t.wbn = ln(0, 10); t.ret = 4'b0001;
    drive(t);
    @(posedge clk);
    #1;
    chk("late_ret_err", 128'(rf_sb_err), 128'h1);
    chk("late_ret_pend", 128'(rf_pending), 128'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
